// File: rtl/ffxkclkx_elastic_if.sv
// Handshake bundle for the elastic delay line: upstream word/ready, downstream word/ready and occupancy.
// The slave modport is the delay line itself; the master modport is the surrounding producer/consumer.
interface ffxkclkx_elastic_if #(
  parameter int WID = 10,
  parameter int K   = 3
);
  localparam int CW = $clog2(K + 1);

  logic           ivld;
  logic [WID-1:0] idat;
  logic           irdy;
  logic           ovld;
  logic [WID-1:0] odat;
  logic           ordy;
  logic [CW-1:0]  ocnt;

  modport master (output ivld, idat, ordy, input irdy, ovld, odat, ocnt);
  modport slave  (input ivld, idat, ordy, output irdy, ovld, odat, ocnt);
endinterface

// File: rtl/ffxkclkx_elastic.sv
// K-stage elastic delay line with per-stage valid, backpressure, bubble collapsing and synchronous flush.
// Define PIPE_DLY_CLR_EN to zero the data of every stage that ends up empty (odat reads 0 when ovld=0).
module ffxkclkx_elastic #(
  parameter int K   = 3,
  parameter int WID = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  ffxkclkx_elastic_if.slave bus
);
  localparam int CW = $clog2(K + 1);

  logic [K:1]     v;
  logic [WID-1:0] d [1:K];
  logic [K:1]     adv;
  logic [K:1]     v_nxt;
  logic [K:0]     v_src;
  logic [WID-1:0] d_src [0:K];
  logic [CW-1:0]  cnt;
  logic           take;
  logic           give;

  // Index 0 is the upstream input, index s>=1 is stage s, so stage s always loads from src[s-1].
  assign v_src = {v, bus.ivld};
  assign d_src[0] = bus.idat;
  for (genvar s = 1; s <= K; s++) begin : g_src
    assign d_src[s] = d[s];
  end

  // A stage may advance if it is empty or everything ahead of it advances; evaluated from the output back.
  always_comb begin
    adv    = '0;
    adv[K] = !v[K] | bus.ordy;
    for (int s = K - 1; s >= 1; s--) begin
      adv[s] = !v[s] | adv[s+1];
    end
  end

  always_comb begin
    v_nxt = v;
    for (int s = 1; s <= K; s++) begin
      if (flush)
        v_nxt[s] = 1'b0;
      else if (adv[s])
        v_nxt[s] = v_src[s-1];
    end
  end

  assign take = bus.ivld & adv[1];
  assign give = v[K] & bus.ordy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v   <= '0;
      cnt <= '0;
      for (int s = 1; s <= K; s++) begin
        d[s] <= '0;
      end
    end else begin
      v <= v_nxt;
      for (int s = 1; s <= K; s++) begin
`ifdef PIPE_DLY_CLR_EN
        if (!v_nxt[s])
          d[s] <= '0;
        else if (adv[s])
          d[s] <= d_src[s-1];
`else
        if (adv[s])
          d[s] <= d_src[s-1];
`endif
      end
      // A word offered during flush is dropped, so the count simply restarts from zero.
      if (flush)
        cnt <= '0;
      else
        cnt <= cnt + CW'(take) - CW'(give);
    end
  end

  assign bus.irdy = adv[1];
  assign bus.ovld = v_src[K];
  assign bus.odat = d_src[K];
  assign bus.ocnt = cnt;

endmodule

// File: tb/tb_ffxkclkx_elastic.sv
// Self-checking bench for ffxkclkx_elastic: directed vector table, hand-written corner sequences
// and a randomized run checked against a word/position queue model of the delay line.
module tb_ffxkclkx_elastic;
  localparam int K   = 3;
  localparam int WID = 10;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  ffxkclkx_elastic_if #(.WID(WID), .K(K)) bus ();

  ffxkclkx_elastic #(.K(K), .WID(WID)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  typedef struct {
    logic           ivld;
    logic [WID-1:0] idat;
    logic           ordy;
    logic           flush;
    logic           eovld;
    logic [WID-1:0] eodat;
    logic [1:0]     eocnt;
    logic           eirdy;
  } vec_t;

  vec_t tbl [17];

  int total = 0;
  int bad   = 0;

  // Reference model: words in arrival order with their stage position (1..K).
  int             m_pos [$];
  logic [WID-1:0] m_dat [$];

  task automatic checkVal(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Words move one stage per edge unless blocked by the word ahead; the head leaves when at K with ordy.
  function automatic bit modelIrdy(input bit o);
    int lim = K;
    int np;
    for (int i = 0; i < m_pos.size(); i++) begin
      if (i == 0 && m_pos[0] == K && o) continue;
      np  = (m_pos[i] + 1 < lim) ? m_pos[i] + 1 : lim;
      lim = np - 1;
    end
    return lim >= 1;
  endfunction

  task automatic modelStep(input bit iv, input logic [WID-1:0] id, input bit o, input bit fl);
    bit rdy;
    int lim = K;
    int np;
    rdy = modelIrdy(o);
    if (m_pos.size() > 0 && m_pos[0] == K && o) begin
      void'(m_pos.pop_front());
      void'(m_dat.pop_front());
    end
    for (int i = 0; i < m_pos.size(); i++) begin
      np       = (m_pos[i] + 1 < lim) ? m_pos[i] + 1 : lim;
      m_pos[i] = np;
      lim      = np - 1;
    end
    if (fl) begin
      m_pos.delete();
      m_dat.delete();
    end else if (iv && rdy) begin
      m_pos.push_back(1);
      m_dat.push_back(id);
    end
  endtask

  task automatic applyStimulus(input bit iv, input logic [WID-1:0] id, input bit o, input bit fl);
    @(negedge clk);
    bus.ivld = iv;
    bus.idat = id;
    bus.ordy = o;
    flush    = fl;
    #2;
  endtask

  task automatic checkOutput();
    bit eo;
    eo = (m_pos.size() > 0) && (m_pos[0] == K);
    checkVal("ovld", int'(bus.ovld), int'(eo));
    checkVal("ocnt", int'(bus.ocnt), m_pos.size());
    checkVal("irdy", int'(bus.irdy), int'(modelIrdy(bus.ordy)));
    if (eo) checkVal("odat", int'(bus.odat), int'(m_dat[0]));
  endtask

  task automatic finishCycle();
    @(posedge clk);
    modelStep(bus.ivld, bus.idat, bus.ordy, flush);
  endtask

  task automatic runCycle(input bit iv, input logic [WID-1:0] id, input bit o, input bit fl);
    applyStimulus(iv, id, o, fl);
    checkOutput();
    finishCycle();
  endtask

  initial begin
    // Streaming with ordy=1, then stall/fill/drain with backpressure (includes full with in+out).
    tbl[0]  = '{1'b1, 10'h3A5, 1'b1, 1'b0, 1'b0, 10'h000, 2'd0, 1'b1};
    tbl[1]  = '{1'b1, 10'h001, 1'b1, 1'b0, 1'b0, 10'h000, 2'd1, 1'b1};
    tbl[2]  = '{1'b1, 10'h2FF, 1'b1, 1'b0, 1'b0, 10'h000, 2'd2, 1'b1};
    tbl[3]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h3A5, 2'd3, 1'b1};
    tbl[4]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h001, 2'd2, 1'b1};
    tbl[5]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h2FF, 2'd1, 1'b1};
    tbl[6]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 2'd0, 1'b1};
    tbl[7]  = '{1'b1, 10'h101, 1'b0, 1'b0, 1'b0, 10'h000, 2'd0, 1'b1};
    tbl[8]  = '{1'b1, 10'h102, 1'b0, 1'b0, 1'b0, 10'h000, 2'd1, 1'b1};
    tbl[9]  = '{1'b1, 10'h103, 1'b0, 1'b0, 1'b0, 10'h000, 2'd2, 1'b1};
    tbl[10] = '{1'b1, 10'h104, 1'b0, 1'b0, 1'b1, 10'h101, 2'd3, 1'b0};
    tbl[11] = '{1'b1, 10'h104, 1'b1, 1'b0, 1'b1, 10'h101, 2'd3, 1'b1};
    tbl[12] = '{1'b1, 10'h105, 1'b1, 1'b0, 1'b1, 10'h102, 2'd3, 1'b1};
    tbl[13] = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h103, 2'd3, 1'b1};
    tbl[14] = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h104, 2'd2, 1'b1};
    tbl[15] = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h105, 2'd1, 1'b1};
    tbl[16] = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 2'd0, 1'b1};

    rst      = 1'b1;
    flush    = 1'b0;
    bus.ivld = 1'b0;
    bus.idat = '0;
    bus.ordy = 1'b0;
    #1;
    checkVal("rst_ovld", int'(bus.ovld), 0);
    checkVal("rst_odat", int'(bus.odat), 0);
    checkVal("rst_ocnt", int'(bus.ocnt), 0);
    checkVal("rst_irdy", int'(bus.irdy), 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i].ivld, tbl[i].idat, tbl[i].ordy, tbl[i].flush);
      checkVal($sformatf("t%0d_ovld", i), int'(bus.ovld), int'(tbl[i].eovld));
      checkVal($sformatf("t%0d_ocnt", i), int'(bus.ocnt), int'(tbl[i].eocnt));
      checkVal($sformatf("t%0d_irdy", i), int'(bus.irdy), int'(tbl[i].eirdy));
      if (tbl[i].eovld)
        checkVal($sformatf("t%0d_odat", i), int'(bus.odat), int'(tbl[i].eodat));
      checkOutput();
      finishCycle();
    end

    // Bubble collapse: a later word closes up behind a stalled head.
    runCycle(1'b1, 10'h0AA, 1'b0, 1'b0);
    runCycle(1'b0, 10'h000, 1'b0, 1'b0);
    runCycle(1'b0, 10'h000, 1'b0, 1'b0);
    runCycle(1'b1, 10'h0BB, 1'b0, 1'b0);
    applyStimulus(1'b0, 10'h000, 1'b0, 1'b0);
    checkVal("bub_ocnt", int'(bus.ocnt), 2);
    checkVal("bub_irdy", int'(bus.irdy), 1);
    checkVal("bub_odat", int'(bus.odat), 'h0AA);
    checkOutput();
    finishCycle();
    applyStimulus(1'b0, 10'h000, 1'b0, 1'b0);
    checkVal("bub2_ocnt", int'(bus.ocnt), 2);
    checkVal("bub2_irdy", int'(bus.irdy), 1);
    checkOutput();
    finishCycle();
    for (int i = 0; i < 4; i++) runCycle(1'b0, 10'h000, 1'b1, 1'b0);

    // Flush with two words held and a word offered in the same cycle.
    runCycle(1'b1, 10'h111, 1'b0, 1'b0);
    runCycle(1'b1, 10'h122, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'h3CC, 1'b0, 1'b1);
    checkVal("fl_pre_ocnt", int'(bus.ocnt), 2);
    checkOutput();
    finishCycle();
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    checkVal("fl_ovld", int'(bus.ovld), 0);
    checkVal("fl_ocnt", int'(bus.ocnt), 0);
`ifdef PIPE_DLY_CLR_EN
    checkVal("fl_odat", int'(bus.odat), 0);
`endif
    checkOutput();
    finishCycle();
    for (int i = 0; i < 4; i++) runCycle(1'b0, 10'h000, 1'b1, 1'b0);

    // Asynchronous reset between edges while streaming.
    runCycle(1'b1, 10'h155, 1'b1, 1'b0);
    runCycle(1'b1, 10'h166, 1'b1, 1'b0);
    runCycle(1'b1, 10'h177, 1'b1, 1'b0);
    @(negedge clk);
    bus.ivld = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkVal("arst_ovld", int'(bus.ovld), 0);
    checkVal("arst_ocnt", int'(bus.ocnt), 0);
    checkVal("arst_odat", int'(bus.odat), 0);
    checkVal("arst_irdy", int'(bus.irdy), 1);
    m_pos.delete();
    m_dat.delete();
    @(negedge clk);
    rst = 1'b0;
    runCycle(1'b1, 10'h1A1, 1'b1, 1'b0);
    runCycle(1'b0, 10'h000, 1'b1, 1'b0);
    runCycle(1'b0, 10'h000, 1'b1, 1'b0);
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    checkVal("post_ovld", int'(bus.ovld), 1);
    checkVal("post_odat", int'(bus.odat), 'h1A1);
    checkOutput();
    finishCycle();

    // Randomized traffic with alternating light/heavy backpressure phases and rare flushes.
    for (int i = 0; i < 400; i++) begin
      bit iv, o, fl;
      logic [WID-1:0] id;
      iv = ($urandom_range(0, 3) != 0);
      o  = ((i / 50) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 31) == 0);
      id = WID'($urandom);
      runCycle(iv, id, o, fl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
